// File: rtl/uart_param_core.sv
// Parametrised full-duplex UART: valid/ready transmitter, oversampling receiver with
// parity/framing error flags, and a 3-bit baud select latched only while both sides are idle.
module uart_param_core #(
   parameter int unsigned CLK_HZ      = 100_000_000,
   parameter int unsigned DATA_BITS   = 8,
   parameter int unsigned PARITY_MODE = 0,
   parameter int unsigned STOP_BITS   = 1,
   parameter int unsigned OVERSAMPLE  = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [2:0]           br_sel,
   input  logic                 rx,
   output logic                 tx,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 rx_parity_err,
   output logic                 rx_frame_err
);

   function automatic int unsigned baud_of(input int unsigned idx);
      case (idx)
         0:       return 1200;
         1:       return 2400;
         2:       return 4800;
         3:       return 9600;
         4:       return 19200;
         5:       return 38400;
         6:       return 57600;
         default: return 115200;
      endcase
   endfunction

   function automatic int unsigned div_of(input int unsigned idx);
      int unsigned d;
      d = CLK_HZ / (baud_of(idx) * OVERSAMPLE);
      return (d == 0) ? 1 : d;
   endfunction

   localparam int unsigned DIV_W = $clog2(div_of(0) + 1);
   localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
   localparam int unsigned BIT_W = 4;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_PAR   = 3'd3;
   localparam logic [2:0] S_STOP  = 3'd4;

   logic [DIV_W-1:0] div_tab [8];
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_div
         assign div_tab[gi] = DIV_W'(div_of(gi));
      end
   endgenerate

   logic [DIV_W-1:0]     div_q, div_d;
   logic [2:0]           tx_state_q, tx_state_d, rx_state_q, rx_state_d;
   logic                 tx_q, tx_d, tx_ready_q, tx_ready_d, tx_par_q, tx_par_d;
   logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
   logic [DIV_W-1:0]     tx_div_q, tx_div_d, rx_div_q, rx_div_d;
   logic [OS_W-1:0]      tx_os_q, tx_os_d, rx_os_q, rx_os_d;
   logic [BIT_W-1:0]     tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
   logic                 tx_stop_q, tx_stop_d;
   logic                 rx_s1_q, rx_s2_q, rx_armed_q, rx_armed_d, rx_pend_q, rx_pend_d;
   logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
   logic                 rx_valid_q, rx_valid_d, rx_perr_q, rx_perr_d, rx_ferr_q, rx_ferr_d;
   logic                 tx_tick, tx_bit_end, rx_tick, rx_mid, rx_full;

   // The active divisor only follows br_sel when neither direction is mid-frame.
   always_comb begin
      div_d = div_q;
      if (tx_state_q == S_IDLE && rx_state_q == S_IDLE) div_d = div_tab[br_sel];
   end

   assign tx_tick    = (tx_div_q == div_q - DIV_W'(1));
   assign tx_bit_end = tx_tick && (tx_os_q == OS_W'(OVERSAMPLE - 1));

   always_comb begin
      tx_state_d = tx_state_q;
      tx_d       = tx_q;
      tx_ready_d = tx_ready_q;
      tx_par_d   = tx_par_q;
      tx_sh_d    = tx_sh_q;
      tx_div_d   = tx_div_q;
      tx_os_d    = tx_os_q;
      tx_bit_d   = tx_bit_q;
      tx_stop_d  = tx_stop_q;
      if (tx_state_q != S_IDLE) begin
         if (tx_tick) begin
            tx_div_d = '0;
            tx_os_d  = tx_bit_end ? '0 : tx_os_q + OS_W'(1);
         end else begin
            tx_div_d = tx_div_q + DIV_W'(1);
         end
      end
      case (tx_state_q)
         S_IDLE: if (tx_valid && tx_ready_q) begin
            tx_sh_d    = tx_data;
            tx_par_d   = (PARITY_MODE == 2) ? ~^tx_data : ^tx_data;
            tx_ready_d = 1'b0;
            tx_d       = 1'b0;
            tx_div_d   = '0;
            tx_os_d    = '0;
            tx_state_d = S_START;
         end
         S_START: if (tx_bit_end) begin
            tx_d       = tx_sh_q[0];
            tx_sh_d    = tx_sh_q >> 1;
            tx_bit_d   = '0;
            tx_state_d = S_DATA;
         end
         S_DATA: if (tx_bit_end) begin
            if (tx_bit_q == BIT_W'(DATA_BITS - 1)) begin
               tx_stop_d = 1'b0;
               if (PARITY_MODE != 0) begin
                  tx_d       = tx_par_q;
                  tx_state_d = S_PAR;
               end else begin
                  tx_d       = 1'b1;
                  tx_state_d = S_STOP;
               end
            end else begin
               tx_d     = tx_sh_q[0];
               tx_sh_d  = tx_sh_q >> 1;
               tx_bit_d = tx_bit_q + BIT_W'(1);
            end
         end
         S_PAR: if (tx_bit_end) begin
            tx_d       = 1'b1;
            tx_stop_d  = 1'b0;
            tx_state_d = S_STOP;
         end
         S_STOP: if (tx_bit_end) begin
            if (tx_stop_q == 1'(STOP_BITS - 1)) begin
               tx_ready_d = 1'b1;
               tx_state_d = S_IDLE;
            end else begin
               tx_stop_d = 1'b1;
            end
         end
         default: tx_state_d = S_IDLE;
      endcase
   end

   assign rx_tick = (rx_div_q == div_q - DIV_W'(1));
   assign rx_mid  = rx_tick && (rx_os_q == OS_W'(OVERSAMPLE / 2 - 1));
   assign rx_full = rx_tick && (rx_os_q == OS_W'(OVERSAMPLE - 1));

   always_comb begin
      rx_state_d = rx_state_q;
      rx_div_d   = rx_div_q;
      rx_os_d    = rx_os_q;
      rx_bit_d   = rx_bit_q;
      rx_armed_d = rx_armed_q;
      rx_pend_d  = rx_pend_q;
      rx_sh_d    = rx_sh_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      rx_perr_d  = rx_perr_q;
      rx_ferr_d  = rx_ferr_q;
      if (rx_state_q != S_IDLE) begin
         if (rx_tick) begin
            rx_div_d = '0;
            rx_os_d  = rx_os_q + OS_W'(1);
         end else begin
            rx_div_d = rx_div_q + DIV_W'(1);
         end
      end
      case (rx_state_q)
         // A break held low must rise again before another start can be seen.
         S_IDLE: begin
            if (rx_s2_q) begin
               rx_armed_d = 1'b1;
            end else if (rx_armed_q) begin
               rx_div_d   = '0;
               rx_os_d    = '0;
               rx_pend_d  = 1'b0;
               rx_state_d = S_START;
            end
         end
         S_START: if (rx_mid) begin
            rx_os_d    = '0;
            rx_bit_d   = '0;
            rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
         end
         S_DATA: if (rx_full) begin
            rx_os_d = '0;
            rx_sh_d = {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
            if (rx_bit_q == BIT_W'(DATA_BITS - 1))
               rx_state_d = (PARITY_MODE != 0) ? S_PAR : S_STOP;
            else
               rx_bit_d = rx_bit_q + BIT_W'(1);
         end
         S_PAR: if (rx_full) begin
            rx_os_d    = '0;
            rx_pend_d  = rx_s2_q ^ (^rx_sh_q) ^ (PARITY_MODE == 2);
            rx_state_d = S_STOP;
         end
         S_STOP: if (rx_full) begin
            rx_os_d    = '0;
            rx_data_d  = rx_sh_q;
            rx_perr_d  = (PARITY_MODE != 0) ? rx_pend_q : 1'b0;
            rx_ferr_d  = ~rx_s2_q;
            rx_valid_d = 1'b1;
            rx_armed_d = 1'b0;
            rx_state_d = S_IDLE;
         end
         default: rx_state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q      <= DIV_W'(div_of(7));
         tx_state_q <= S_IDLE;
         tx_q       <= 1'b1;
         tx_ready_q <= 1'b1;
         tx_par_q   <= 1'b0;
         tx_sh_q    <= '0;
         tx_div_q   <= '0;
         tx_os_q    <= '0;
         tx_bit_q   <= '0;
         tx_stop_q  <= 1'b0;
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_state_q <= S_IDLE;
         rx_div_q   <= '0;
         rx_os_q    <= '0;
         rx_bit_q   <= '0;
         rx_armed_q <= 1'b0;
         rx_pend_q  <= 1'b0;
         rx_sh_q    <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         rx_perr_q  <= 1'b0;
         rx_ferr_q  <= 1'b0;
      end else begin
         div_q      <= div_d;
         tx_state_q <= tx_state_d;
         tx_q       <= tx_d;
         tx_ready_q <= tx_ready_d;
         tx_par_q   <= tx_par_d;
         tx_sh_q    <= tx_sh_d;
         tx_div_q   <= tx_div_d;
         tx_os_q    <= tx_os_d;
         tx_bit_q   <= tx_bit_d;
         tx_stop_q  <= tx_stop_d;
         rx_s1_q    <= rx;
         rx_s2_q    <= rx_s1_q;
         rx_state_q <= rx_state_d;
         rx_div_q   <= rx_div_d;
         rx_os_q    <= rx_os_d;
         rx_bit_q   <= rx_bit_d;
         rx_armed_q <= rx_armed_d;
         rx_pend_q  <= rx_pend_d;
         rx_sh_q    <= rx_sh_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         rx_perr_q  <= rx_perr_d;
         rx_ferr_q  <= rx_ferr_d;
      end
   end

   assign tx            = tx_q;
   assign tx_ready      = tx_ready_q;
   assign rx_data       = rx_data_q;
   assign rx_valid      = rx_valid_q;
   assign rx_parity_err = rx_perr_q;
   assign rx_frame_err  = rx_ferr_q;

endmodule

// File: tb/tb_uart_param_core.sv
// Directed bench for uart_param_core: instance A is 8N1, instance B is 8E2 with optional loopback.
module tb_uart_param_core;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] br_sel_a, br_sel_b;
   logic       rx_a, rx_drv_b, loop_b;
   wire        rx_b;
   logic       tx_a, tx_b, tx_ready_a, tx_ready_b;
   logic [7:0] tx_data_a, tx_data_b, rx_data_a, rx_data_b;
   logic       tx_valid_a, tx_valid_b, rx_valid_a, rx_valid_b;
   logic       perr_a, perr_b, ferr_a, ferr_b;

   int errors = 0;
   int checks = 0;
   int n, base;

   int         cap_cnt_a = 0, cap_cnt_b = 0;
   logic [7:0] cap_data_a [8], cap_data_b [8];
   logic       cap_perr_a [8], cap_perr_b [8], cap_ferr_a [8], cap_ferr_b [8];

   always #5 clk = ~clk;

   assign rx_b = loop_b ? tx_b : rx_drv_b;

   uart_param_core #(.CLK_HZ(1_843_200), .DATA_BITS(8), .PARITY_MODE(0),
                     .STOP_BITS(1), .OVERSAMPLE(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .br_sel(br_sel_a), .rx(rx_a), .tx(tx_a),
      .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
      .rx_data(rx_data_a), .rx_valid(rx_valid_a),
      .rx_parity_err(perr_a), .rx_frame_err(ferr_a));

   uart_param_core #(.CLK_HZ(1_843_200), .DATA_BITS(8), .PARITY_MODE(1),
                     .STOP_BITS(2), .OVERSAMPLE(16)) dut_b (
      .clk(clk), .rst_n(rst_n), .br_sel(br_sel_b), .rx(rx_b), .tx(tx_b),
      .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
      .rx_data(rx_data_b), .rx_valid(rx_valid_b),
      .rx_parity_err(perr_b), .rx_frame_err(ferr_b));

   // Record every received frame; checks read these records.
   always @(negedge clk) begin
      if (rx_valid_a) begin
         if (cap_cnt_a < 8) begin
            cap_data_a[cap_cnt_a] = rx_data_a;
            cap_perr_a[cap_cnt_a] = perr_a;
            cap_ferr_a[cap_cnt_a] = ferr_a;
         end
         cap_cnt_a++;
         $display("rx A: data=%02h perr=%0b ferr=%0b", rx_data_a, perr_a, ferr_a);
      end
      if (rx_valid_b) begin
         if (cap_cnt_b < 8) begin
            cap_data_b[cap_cnt_b] = rx_data_b;
            cap_perr_b[cap_cnt_b] = perr_b;
            cap_ferr_b[cap_cnt_b] = ferr_b;
         end
         cap_cnt_b++;
         $display("rx B: data=%02h perr=%0b ferr=%0b", rx_data_b, perr_b, ferr_b);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive a frame on an rx pin, one bit per 16 cycles, LSB of bits first, then idle high.
   task automatic drive_frame(input logic to_b, input logic [11:0] bits, input int nb);
      for (int i = 0; i < nb; i++) begin
         if (to_b) rx_drv_b = bits[i]; else rx_a = bits[i];
         repeat (16) @(negedge clk);
      end
      if (to_b) rx_drv_b = 1'b1; else rx_a = 1'b1;
      repeat (24) @(negedge clk);
   endtask

   logic [7:0] word;
   logic       exp_bit;

   initial begin
      rst_n = 1'b0;
      br_sel_a = 3'd7; br_sel_b = 3'd7;
      rx_a = 1'b0; rx_drv_b = 1'b0; loop_b = 1'b0;
      tx_valid_a = 1'b1; tx_valid_b = 1'b1;
      tx_data_a = 8'h00; tx_data_b = 8'h00;

      // Reset held with rx low and tx_valid high
      repeat (3) @(negedge clk);
      chk("rst_tx_a", tx_a, 1);         chk("rst_ready_a", tx_ready_a, 1);
      chk("rst_rxv_a", rx_valid_a, 0);  chk("rst_perr_a", perr_a, 0);
      chk("rst_ferr_a", ferr_a, 0);     chk("rst_rxd_a", rx_data_a, 0);
      chk("rst_tx_b", tx_b, 1);         chk("rst_ready_b", tx_ready_b, 1);
      chk("rst_rxv_b", rx_valid_b, 0);  chk("rst_perr_b", perr_b, 0);
      chk("rst_ferr_b", ferr_b, 0);
      rx_a = 1'b1; rx_drv_b = 1'b1; tx_valid_a = 1'b0; tx_valid_b = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // 8N1 transmit of 0xA5, checked every cycle
      word = 8'hA5;
      tx_data_a = word; tx_valid_a = 1'b1;
      @(posedge clk);
      @(negedge clk); tx_valid_a = 1'b0;
      for (int c = 1; c <= 160; c++) begin
         if (c <= 16) exp_bit = 1'b0;
         else if (c <= 144) exp_bit = word[(c - 17) / 16];
         else exp_bit = 1'b1;
         chk($sformatf("a5_tx_c%0d", c), tx_a, exp_bit);
         chk($sformatf("a5_ready_c%0d", c), tx_ready_a, 0);
         @(negedge clk);
      end
      chk("a5_ready_c161", tx_ready_a, 1);
      chk("a5_tx_c161", tx_a, 1);
      $display("tx A: word=%02h sent", word);

      // Loopback 8E2: 0x3C then 0xFF back-to-back
      loop_b = 1'b1;
      base = cap_cnt_b;
      tx_data_b = 8'h3C; tx_valid_b = 1'b1;
      @(posedge clk);
      @(negedge clk); tx_data_b = 8'hFF;
      n = 0;
      while (!tx_ready_b && n < 400) begin @(negedge clk); n++; end
      chk("b_frame_len", n, 192);
      @(posedge clk);
      @(negedge clk); tx_valid_b = 1'b0;
      n = 0;
      while (cap_cnt_b < base + 2 && n < 600) begin @(negedge clk); n++; end
      chk("loop_count", cap_cnt_b - base, 2);
      chk("loop_d0", cap_data_b[base], 8'h3C);
      chk("loop_p0", cap_perr_b[base], 0);
      chk("loop_f0", cap_ferr_b[base], 0);
      chk("loop_d1", cap_data_b[base + 1], 8'hFF);
      chk("loop_p1", cap_perr_b[base + 1], 0);
      chk("loop_f1", cap_ferr_b[base + 1], 0);
      repeat (20) @(negedge clk);
      loop_b = 1'b0;
      repeat (4) @(negedge clk);

      // Wrong parity on 0x3C (correct even parity is 0)
      base = cap_cnt_b;
      drive_frame(1'b1, {1'b1, 1'b1, 1'b1, 8'h3C, 1'b0}, 12);
      chk("perr_count", cap_cnt_b - base, 1);
      chk("perr_data", cap_data_b[base], 8'h3C);
      chk("perr_flag", cap_perr_b[base], 1);
      chk("perr_ferr", cap_ferr_b[base], 0);

      // Stop bit low on 0x55 (good parity 0)
      base = cap_cnt_b;
      drive_frame(1'b1, {1'b1, 1'b0, 1'b0, 8'h55, 1'b0}, 12);
      chk("ferr_count", cap_cnt_b - base, 1);
      chk("ferr_data", cap_data_b[base], 8'h55);
      chk("ferr_flag", cap_ferr_b[base], 1);
      chk("ferr_perr", cap_perr_b[base], 0);

      // Good 8N1 frame on A, then a 4-cycle glitch
      base = cap_cnt_a;
      drive_frame(1'b0, {2'b11, 1'b1, 8'h96, 1'b0}, 10);
      chk("a_rx_count", cap_cnt_a - base, 1);
      chk("a_rx_data", cap_data_a[base], 8'h96);
      chk("a_rx_perr", cap_perr_a[base], 0);
      chk("a_rx_ferr", cap_ferr_a[base], 0);
      base = cap_cnt_a;
      rx_a = 1'b0; repeat (4) @(negedge clk);
      rx_a = 1'b1; repeat (100) @(negedge clk);
      chk("glitch_no_rx", cap_cnt_a - base, 0);

      // Reset pulse mid data bit of 0x00
      tx_data_a = 8'h00; tx_valid_a = 1'b1;
      @(posedge clk);
      @(negedge clk); tx_valid_a = 1'b0;
      repeat (40) @(negedge clk);
      chk("abort_pre_tx", tx_a, 0);
      chk("abort_pre_ready", tx_ready_a, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_tx", tx_a, 1);
      chk("abort_ready", tx_ready_a, 1);
      chk("abort_rxv", rx_valid_a, 0);
      @(negedge clk); rst_n = 1'b1;
      repeat (4) @(negedge clk);
      $display("tx A: reset abort done");

      // br_sel 7 -> 3 mid-frame: current frame stays at 16 cycles/bit
      tx_data_a = 8'h0F; tx_valid_a = 1'b1;
      @(posedge clk);
      @(negedge clk); tx_valid_a = 1'b0;
      n = 1;
      while (!tx_ready_a && n < 3000) begin
         if (n == 50) br_sel_a = 3'd3;
         @(negedge clk); n++;
      end
      chk("div_cur_frame", n, 161);
      tx_data_a = 8'h01; tx_valid_a = 1'b1;
      @(posedge clk);
      @(negedge clk); tx_valid_a = 1'b0;
      n = 1;
      while (!tx_ready_a && n < 3000) begin @(negedge clk); n++; end
      chk("div_next_frame", n, 1921);
      $display("tx A: divisor switch done");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
